// File: rtl/neo_crom_fetch.sv
// neo_crom_fetch: sprite slice C-ROM fetch sequencer feeding the ZMC2 dot shifter.
// Define CROM_FETCH_UNDERRUN_EN to add the saturating UNDERRUN_CNT output.
module neo_crom_fetch #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W = 25
) (
  input  logic              CLK_12M,
  input  logic              RESET,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [19:0]       REQ_TILE,
  input  logic [3:0]        REQ_LINE,
  input  logic              REQ_HFLIP,
  input  logic [8:0]        REQ_X,
  output logic              MEM_REQ,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic              MEM_ACK,
  input  logic [31:0]       MEM_DATA,
  output logic [31:0]       CR,
  output logic              LOAD,
  output logic              H,
  output logic              EVEN,
  output logic              PIX_VALID,
`ifdef CROM_FETCH_UNDERRUN_EN
  output logic [15:0]       UNDERRUN_CNT,
`endif
  output logic [8:0]        PIX_X
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {F_IDLE, F_RD0, F_RD1} fstate_t;
  typedef enum logic {E_IDLE, E_SHIFT} estate_t;
  typedef struct packed {
    logic [31:0] data;
    logic        h;
    logic        even;
    logic [8:0]  xb;
  } entry_t;
  fstate_t           r_fs;
  estate_t           r_es;
  entry_t            r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wp, r_rp;
  logic [CW-1:0]     r_cnt;
  logic              r_rdy_en, r_hflip;
  logic [8:0]        r_x, r_xb;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_req;
  logic [1:0]        r_phase;
  logic              w_accept, w_push, w_pop;
  logic [1:0]        w_ph_n;
  entry_t            w_in, w_out;
  assign MEM_REQ   = r_mem_req;
  assign MEM_ADDR  = r_mem_addr;
  assign REQ_READY = r_rdy_en && r_fs == F_IDLE && r_cnt <= CW'(FIFO_DEPTH - 2);
  assign w_accept  = REQ_VALID && REQ_READY;
  assign w_push    = r_fs != F_IDLE && MEM_ACK;
  assign w_pop     = r_cnt != '0 && (r_es == E_IDLE || r_phase == 2'd3);
  assign w_ph_n    = r_phase + 2'd1;
  assign w_in      = {MEM_DATA, ~r_hflip, r_x[0], r_fs == F_RD1 ? r_x + 9'd8 : r_x};
  assign w_out     = r_mem[r_rp];
  // Second read flips only the HALF bit, which sits just above LINE.
  always_ff @(negedge CLK_12M)
    if (RESET) begin
      r_fs       <= F_IDLE;
      r_rdy_en   <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_hflip    <= 1'b0;
      r_x        <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      case (r_fs)
        F_IDLE: if (w_accept) begin
          r_mem_addr <= ADDR_W'({REQ_TILE, REQ_HFLIP, REQ_LINE});
          r_mem_req  <= 1'b1;
          r_hflip    <= REQ_HFLIP;
          r_x        <= REQ_X;
          r_fs       <= F_RD0;
        end
        F_RD0: if (MEM_ACK) begin
          r_mem_addr <= r_mem_addr ^ ADDR_W'(16);
          r_fs       <= F_RD1;
        end
        F_RD1: if (MEM_ACK) begin
          r_mem_req <= 1'b0;
          r_fs      <= F_IDLE;
        end
        default: r_fs <= F_IDLE;
      endcase
    end
  always_ff @(negedge CLK_12M)
    if (w_push) r_mem[r_wp] <= w_in;
  always_ff @(negedge CLK_12M)
    if (RESET) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
`ifdef CROM_FETCH_UNDERRUN_EN
  logic [15:0] r_uc;
  assign UNDERRUN_CNT = r_uc;
`endif
  // Phase 0 is the LOAD cycle; an empty FIFO after phase 3 is an underrun.
  always_ff @(negedge CLK_12M)
    if (RESET) begin
      r_es      <= E_IDLE;
      r_phase   <= '0;
      r_xb      <= '0;
      CR        <= '0;
      LOAD      <= 1'b0;
      H         <= 1'b1;
      EVEN      <= 1'b0;
      PIX_VALID <= 1'b0;
      PIX_X     <= '0;
`ifdef CROM_FETCH_UNDERRUN_EN
      r_uc      <= '0;
`endif
    end else if (w_pop) begin
      r_es      <= E_SHIFT;
      r_phase   <= '0;
      r_xb      <= w_out.xb;
      CR        <= w_out.data;
      LOAD      <= 1'b1;
      H         <= w_out.h;
      EVEN      <= w_out.even;
      PIX_VALID <= 1'b1;
      PIX_X     <= w_out.xb;
    end else if (r_es == E_SHIFT && r_phase != 2'd3) begin
      LOAD    <= 1'b0;
      r_phase <= w_ph_n;
      PIX_X   <= r_xb + {6'd0, w_ph_n, 1'b0};
    end else begin
      LOAD      <= 1'b0;
      PIX_VALID <= 1'b0;
      r_es      <= E_IDLE;
`ifdef CROM_FETCH_UNDERRUN_EN
      if (r_es == E_SHIFT && r_uc != 16'hFFFF) r_uc <= r_uc + 16'd1;
`endif
    end
endmodule

// File: doc/neo_crom_fetch.md
# neo_crom_fetch

Sprite graphics fetch sequencer sitting directly upstream of the ZMC2 dot shifter. Accepts one sprite slice request (tile, row, flip, X) at a time and issues two 32-bit C-ROM reads, one per 8-pixel half-tile. It buffers the returned words in a 4-entry FIFO and drives CR/LOAD/H/EVEN to the shifter at one word per 4 clocks, with a matching pixel X coordinate for the line-buffer writer.

## Interface
Parameters:
- FIFO_DEPTH, 4, word FIFO entries; power of two, ≥2.
- ADDR_W, 25, C-ROM word address width.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- CLK_12M  in  1  pixel clock; all state updates on negedge.
- RESET  in  1  synchronous active-high reset.
- REQ_VALID  in  1  slice request valid.
- REQ_READY  out  1  slice request accepted when both high.
- REQ_TILE  in  20  tile number.
- REQ_LINE  in  4  row within tile.
- REQ_HFLIP  in  1  horizontal flip.
- REQ_X  in  9  screen X of leftmost pixel.
- MEM_REQ  out  1  C-ROM read request.
- MEM_ADDR  out  ADDR_W  word address {TILE, HALF, LINE}.
- MEM_ACK  in  1  read complete; MEM_DATA valid this cycle.
- MEM_DATA  in  32  C-ROM word (C1/C2 interleaved).
- CR  out  32  word to dot shifter.
- LOAD  out  1  shifter load strobe.
- H  out  1  shift direction; equals ~HFLIP of current word.
- EVEN  out  1  X parity of current word; equals X base [0].
- PIX_VALID  out  1  CR/H/EVEN describe live pixels this cycle.
- PIX_X  out  9  screen X of pixel pair this cycle.
- UNDERRUN_CNT  out  16  present only with CROM_FETCH_UNDERRUN_EN.

## Operation
- Fetch FSM states F_IDLE, F_RD0, F_RD1.
  - F_IDLE: REQ_READY=1 iff free FIFO slots ≥2; on handshake latch request, go F_RD0.
  - F_RD0: first half; HALF=0 (columns 0–7) if HFLIP=0, else HALF=1. On MEM_ACK, push entry, go F_RD1.
  - F_RD1: other half; on MEM_ACK, push, go F_IDLE.
- FIFO entry: {data[31:0], H, EVEN, xbase[8:0]}. Word0 xbase=REQ_X; word1 xbase=REQ_X+8, mod 512 (9-bit wrap, no saturation).
- Emit FSM states E_IDLE, E_SHIFT, with 2-bit phase counter.
  - E_IDLE: if FIFO non-empty, pop, assert LOAD, CR=entry data, phase=0, go E_SHIFT.
  - E_SHIFT: phase 1..3 with LOAD=0. After phase 3, pop and LOAD again if non-empty, else go E_IDLE.
- PIX_VALID=1 during LOAD cycle and the 3 shift cycles. PIX_X = xbase + 2·phase (mod 512). H/EVEN are held for the whole word.
- Underrun: FIFO empty at phase-3 boundary. Emitter goes idle and PIX_VALID=0; no garbage LOAD.
- Simultaneous push and pop on the same edge is legal; occupancy is unchanged.

## Timing
- MEM_REQ/MEM_ADDR stay stable from assertion until the cycle MEM_ACK is sampled high.
- The next read may assert MEM_REQ the cycle after ACK.
- MEM_ACK while MEM_REQ=0 is ignored.
- Request accepted at edge t → MEM_REQ high from t+1.
- ACK at edge a → earliest LOAD at a+1 if emitter idle.
- Sustained rate: 1 slice / 8 clocks, with zero underrun if each read completes ≤3 clocks.
- Reset values: REQ_READY=0 in the reset cycle, then 1. MEM_REQ=0, MEM_ADDR=0, CR=0, LOAD=0, H=1, EVEN=0, PIX_VALID=0, PIX_X=0, UNDERRUN_CNT=0. FIFO is emptied.
- Reset mid-read: MEM_REQ drops next edge, and a late ACK is discarded.

## Configuration
- CROM_FETCH_UNDERRUN_EN defined: UNDERRUN_CNT port exists.
  - Increments by 1 on each underrun event, counting each transition to E_IDLE caused by an empty FIFO at the phase-3 boundary.
  - Saturates at 0xFFFF; cleared only by RESET.
- Undefined: port and counter are absent; behaviour otherwise identical.

## Test plan
- Single slice, zero-wait memory: TILE=0x00123, LINE=5, HFLIP=0, X=100.
  - Expect MEM_ADDR 0x0002465 then 0x0002475.
  - Expect LOADs 4 clocks apart, PIX_X 100,102,104,106,108,…,114, H=1, EVEN=0.
- HFLIP=1, X=511:
  - Expect first address has HALF=1, H=0, EVEN=1.
  - Expect PIX_X 511,1,3,5, then 7,9,11,13 (wrap).
- Back-to-back slices with 2-clock read latency: LOAD every 4 clocks continuously, PIX_VALID never drops across 3 slices.
- Slow memory with 10-clock ACK delay: PIX_VALID drops after each word, LOAD never fires on an empty FIFO, UNDERRUN_CNT=2 per slice (with macro).
- Backpressure: hold the emitter busy so the FIFO fills with 4 entries; expect REQ_READY=0 until a pop frees 2 slots.
- RESET asserted while MEM_REQ=1; ACK arrives 2 clocks later.
  - Expect all outputs at reset values, FIFO empty, and no LOAD.
